// File: rtl/treeval_pkg.sv
// rtl/treeval_pkg.sv - shared state encoding, widths and saturating arithmetic for treeval_p
package treeval_pkg;

    localparam int DEF_N_NODES  = 1024;
    localparam int DEF_N_ACT    = 8;
    localparam int DEF_W_REWARD = 11;
    localparam int DEF_W_WEIGHT = 8;
    localparam int CALC_W       = 64;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_ACCUM,
        ST_COMMIT,
        ST_DONE
    } state_e;

    typedef logic signed [CALC_W-1:0] calc_t;

    // Clamp a wide intermediate into the signed range of a w-bit value.
    function automatic calc_t sat_to(input calc_t v, input int w);
        calc_t hi;
        calc_t lo;
        calc_t r;
        hi = (calc_t'(1) <<< (w - 1)) - calc_t'(1);
        lo = -hi - calc_t'(1);
        if (v > hi) begin
            r = hi;
        end else if (v < lo) begin
            r = lo;
        end else begin
            r = v;
        end
        return r;
    endfunction

    function automatic calc_t sat_add(input calc_t a, input calc_t b, input int w);
        return sat_to(a + b, w);
    endfunction

    // Weight is a non-negative fixed-point fraction with w_wt-1 fractional bits.
    function automatic calc_t sat_mul_shift(input calc_t r, input calc_t wt,
                                            input int w_rew, input int w_wt);
        return sat_to((r * wt) >>> (w_wt - 1), w_rew);
    endfunction

endpackage

// File: rtl/treeval_argmax.sv
// rtl/treeval_argmax.sv - combinational best-of-N selector over the used slots of the action buffer
module treeval_argmax #(
    parameter int N  = 8,
    parameter int W  = 11,
    parameter int WI = $clog2(N)
) (
    input  logic signed [W-1:0]  vals_i [N],
    input  logic        [N-1:0]  used_i,
    input  logic                 min_i,
    output logic signed [W-1:0]  val_o,
    output logic        [WI-1:0] idx_o,
    output logic                 any_o
);

    localparam int NT = 2 * N - 1;

    // Heap-ordered reduction: left subtrees always hold lower indices, so the
    // right side only wins when strictly better, giving lowest-index ties.
    always_comb begin : reduce
        logic signed [W-1:0]  t_val [NT];
        logic        [WI-1:0] t_idx [NT];
        logic        [NT-1:0] t_ok;
        logic                 pick_r;
        pick_r = 1'b0;
        t_ok   = '0;
        for (int i = 0; i < NT; i++) begin
            t_val[i] = '0;
            t_idx[i] = '0;
        end
        for (int i = 0; i < N; i++) begin
            t_val[N-1+i] = vals_i[i];
            t_idx[N-1+i] = WI'(i);
            t_ok[N-1+i]  = used_i[i];
        end
        for (int k = N - 2; k >= 0; k--) begin
            pick_r = t_ok[2*k+2] &&
                     (!t_ok[2*k+1] ||
                      (min_i ? (t_val[2*k+2] < t_val[2*k+1])
                             : (t_val[2*k+2] > t_val[2*k+1])));
            t_val[k] = pick_r ? t_val[2*k+2] : t_val[2*k+1];
            t_idx[k] = pick_r ? t_idx[2*k+2] : t_idx[2*k+1];
            t_ok[k]  = t_ok[2*k+1] | t_ok[2*k+2];
        end
        val_o = t_val[0];
        idx_o = t_idx[0];
        any_o = t_ok[0];
    end

endmodule

// File: rtl/treeval_p.sv
// rtl/treeval_p.sv - decision tree evaluator: backward expectation sweep with saturation and max/min policy
module treeval_p
    import treeval_pkg::*;
#(
    parameter int N_NODES  = DEF_N_NODES,
    parameter int N_ACT    = DEF_N_ACT,
    parameter int W_REWARD = DEF_W_REWARD,
    parameter int W_WEIGHT = DEF_W_WEIGHT,
    parameter int W_ADDR   = $clog2(N_NODES),
    parameter int W_ACT    = $clog2(N_ACT)
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       wr_en,
    input  logic        [W_ADDR-1:0]   wr_addr,
    input  logic        [W_ADDR-1:0]   wr_parent,
    input  logic        [W_ACT-1:0]    wr_action,
    input  logic signed [W_REWARD-1:0] wr_reward,
    input  logic        [W_WEIGHT-1:0] wr_weight,
    output logic                       wr_ready,
    input  logic                       cfg_nodes_en,
    input  logic        [W_ADDR:0]     cfg_nodes,
    input  logic                       cfg_min,
    input  logic                       start,
    output logic                       busy,
    output logic                       done,
    output logic signed [W_REWARD-1:0] exp,
    output logic        [W_ACT-1:0]    act
);

    localparam int WN = W_ADDR + 1;
    localparam logic signed [W_REWARD-1:0] MAX_V = {1'b0, {(W_REWARD-1){1'b1}}};
    localparam logic signed [W_REWARD-1:0] MIN_V = {1'b1, {(W_REWARD-1){1'b0}}};

    logic signed [W_REWARD-1:0] rew_mem [N_NODES];
    logic        [W_ADDR-1:0]   par_mem [N_NODES];
    logic        [W_ACT-1:0]    act_mem [N_NODES];
    logic        [W_WEIGHT-1:0] wgt_mem [N_NODES];

    state_e                     state_q;
    logic        [W_ADDR-1:0]   cur_q;
    logic        [W_ADDR-1:0]   commit_par_q;
    logic        [W_ADDR:0]     num_nodes_q;
    logic                       min_q;
    logic                       busy_q;
    logic                       done_q;
    logic signed [W_REWARD-1:0] exp_q;
    logic        [W_ACT-1:0]    act_q;
    logic        [W_ACT-1:0]    root_act_q;
    logic signed [W_REWARD-1:0] buf_q [N_ACT];
    logic        [N_ACT-1:0]    used_q;

    logic signed [W_REWARD-1:0] rew_cur;
    logic        [W_WEIGHT-1:0] wgt_cur;
    logic        [W_ACT-1:0]    act_cur;
    logic        [W_ADDR-1:0]   par_cur;
    logic        [W_ADDR-1:0]   par_prev;
    calc_t                      prod_c;
    calc_t                      acc_c;
    logic signed [W_REWARD-1:0] acc_val;
    logic signed [W_REWARD-1:0] ident;
    logic signed [W_REWARD-1:0] best_val;
    logic        [W_ACT-1:0]    best_idx;
    logic                       best_any;
    logic                       root_hit;
    logic                       last_child;
    logic                       unused_acc;

    function automatic logic [W_ADDR:0] clamp_nodes(input logic [W_ADDR:0] n);
        logic [W_ADDR:0] r;
        if (n == '0) begin
            r = WN'(1);
        end else if (n > WN'(N_NODES)) begin
            r = WN'(N_NODES);
        end else begin
            r = n;
        end
        return r;
    endfunction

    assign rew_cur  = rew_mem[cur_q];
    assign wgt_cur  = wgt_mem[cur_q];
    assign act_cur  = act_mem[cur_q];
    assign par_cur  = par_mem[cur_q];
    assign par_prev = par_mem[cur_q - 1'b1];

    always_comb begin
        prod_c = sat_mul_shift(calc_t'(rew_cur), calc_t'({1'b0, wgt_cur}), W_REWARD, W_WEIGHT);
        if (used_q[act_cur]) begin
            acc_c = sat_add(calc_t'(buf_q[act_cur]), prod_c, W_REWARD);
        end else begin
            acc_c = prod_c;
        end
    end

    assign acc_val    = acc_c[W_REWARD-1:0];
    assign unused_acc = ^acc_c[CALC_W-1:W_REWARD];
    assign ident      = min_q ? MAX_V : MIN_V;
    assign root_hit   = (commit_par_q == '0) && best_any;
    assign last_child = (cur_q == W_ADDR'(1)) || (par_prev != par_cur);

    treeval_argmax #(
        .N  (N_ACT),
        .W  (W_REWARD),
        .WI (W_ACT)
    ) u_argmax (
        .vals_i (buf_q),
        .used_i (used_q),
        .min_i  (min_q),
        .val_o  (best_val),
        .idx_o  (best_idx),
        .any_o  (best_any)
    );

    // Node store has no reset; host loads and sweep commits are mutually exclusive via busy.
    always_ff @(posedge clk) begin
        if (wr_en && !busy_q) begin
            rew_mem[wr_addr] <= wr_reward;
            par_mem[wr_addr] <= wr_parent;
            act_mem[wr_addr] <= wr_action;
            wgt_mem[wr_addr] <= wr_weight;
        end else if (state_q == ST_COMMIT && best_any) begin
            rew_mem[commit_par_q] <= best_val;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            cur_q        <= '0;
            commit_par_q <= '0;
            num_nodes_q  <= WN'(N_NODES);
            min_q        <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            exp_q        <= '0;
            act_q        <= '0;
            root_act_q   <= '0;
            used_q       <= '0;
            for (int i = 0; i < N_ACT; i++) begin
                buf_q[i] <= '0;
            end
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (cfg_nodes_en) begin
                        num_nodes_q <= clamp_nodes(cfg_nodes);
                    end
                    if (start) begin
                        busy_q <= 1'b1;
                        if (num_nodes_q >= WN'(2)) begin
                            min_q   <= cfg_min;
                            cur_q   <= W_ADDR'(num_nodes_q - WN'(1));
                            state_q <= ST_CLEAR;
                        end else begin
                            exp_q   <= rew_mem[0];
                            act_q   <= root_act_q;
                            done_q  <= 1'b1;
                            state_q <= ST_DONE;
                        end
                    end
                end
                ST_CLEAR: begin
                    for (int i = 0; i < N_ACT; i++) begin
                        buf_q[i] <= ident;
                    end
                    used_q  <= '0;
                    state_q <= ST_ACCUM;
                end
                ST_ACCUM: begin
                    buf_q[act_cur]  <= acc_val;
                    used_q[act_cur] <= 1'b1;
                    if (last_child) begin
                        commit_par_q <= par_cur;
                        state_q      <= ST_COMMIT;
                    end else begin
                        cur_q <= cur_q - 1'b1;
                    end
                end
                ST_COMMIT: begin
                    if (root_hit) begin
                        root_act_q <= best_idx;
                    end
                    if (cur_q == W_ADDR'(1)) begin
                        // The root commit lands in the store on this same edge, so forward it.
                        exp_q   <= root_hit ? best_val : rew_mem[0];
                        act_q   <= root_hit ? best_idx : root_act_q;
                        done_q  <= 1'b1;
                        state_q <= ST_DONE;
                    end else begin
                        cur_q   <= cur_q - 1'b1;
                        state_q <= ST_CLEAR;
                    end
                end
                ST_DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign wr_ready = !busy_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign exp      = exp_q;
    assign act      = act_q;

endmodule

// File: tb/tb_treeval_p.sv
// tb/tb_treeval_p.sv - table-driven self-checking bench for treeval_p
module tb_treeval_p;

    localparam int W_ADDR   = 10;
    localparam int W_ACT    = 3;
    localparam int W_REWARD = 11;
    localparam int W_WEIGHT = 8;

    typedef struct packed {
        int par;
        int act;
        int rew;
        int wt;
    } node_t;

    typedef struct packed {
        int first;
        int cnt;
        int nodes;
        bit mn;
        int e_exp;
        int e_act;
        int e_lat;
    } vec_t;

    logic                       clk = 1'b0;
    logic                       rst_n = 1'b1;
    logic                       wr_en = 1'b0;
    logic        [W_ADDR-1:0]   wr_addr = '0;
    logic        [W_ADDR-1:0]   wr_parent = '0;
    logic        [W_ACT-1:0]    wr_action = '0;
    logic signed [W_REWARD-1:0] wr_reward = '0;
    logic        [W_WEIGHT-1:0] wr_weight = '0;
    logic                       wr_ready;
    logic                       cfg_nodes_en = 1'b0;
    logic        [W_ADDR:0]     cfg_nodes = '0;
    logic                       cfg_min = 1'b0;
    logic                       start = 1'b0;
    logic                       busy;
    logic                       done;
    logic signed [W_REWARD-1:0] exp_w;
    logic        [W_ACT-1:0]    act_w;

    int passed = 0;
    int total  = 0;

    node_t ntab [16];
    vec_t  vtab [10];

    always #5 clk = ~clk;

    treeval_p dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .wr_en        (wr_en),
        .wr_addr      (wr_addr),
        .wr_parent    (wr_parent),
        .wr_action    (wr_action),
        .wr_reward    (wr_reward),
        .wr_weight    (wr_weight),
        .wr_ready     (wr_ready),
        .cfg_nodes_en (cfg_nodes_en),
        .cfg_nodes    (cfg_nodes),
        .cfg_min      (cfg_min),
        .start        (start),
        .busy         (busy),
        .done         (done),
        .exp          (exp_w),
        .act          (act_w)
    );

    task automatic check(input string name, input int got, input int expv);
        total++;
        if (got == expv) begin
            passed++;
        end else begin
            $display("FAIL %s: got %0d, expected %0d", name, got, expv);
        end
    endtask

    task automatic wr_node(input int addr, input int par, input int a, input int rew, input int wt);
        @(negedge clk);
        wr_en     = 1'b1;
        wr_addr   = W_ADDR'(addr);
        wr_parent = W_ADDR'(par);
        wr_action = W_ACT'(a);
        wr_reward = W_REWARD'(rew);
        wr_weight = W_WEIGHT'(wt);
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic set_nodes(input int n);
        @(negedge clk);
        cfg_nodes_en = 1'b1;
        cfg_nodes    = (W_ADDR+1)'(n);
        @(negedge clk);
        cfg_nodes_en = 1'b0;
    endtask

    // lat counts cycles from the start cycle to the cycle where done is seen.
    task automatic start_wait(input bit mn, output int lat);
        @(negedge clk);
        start   = 1'b1;
        cfg_min = mn;
        @(negedge clk);
        start = 1'b0;
        lat   = 1;
        while (!done && lat < 300) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic load_vec(input vec_t v);
        for (int j = 0; j < v.cnt; j++) begin
            wr_node(j + 1, ntab[v.first+j].par, ntab[v.first+j].act,
                    ntab[v.first+j].rew, ntab[v.first+j].wt);
        end
        set_nodes(v.nodes);
    endtask

    initial begin
        int lat;
        int ndone;
        int rdy;
        int nbusy;
        int e;
        int a;

        ntab[0]  = '{0, 0, 100, 128};
        ntab[1]  = '{0, 1, 50, 64};
        ntab[2]  = '{0, 1, 200, 64};
        ntab[3]  = '{0, 0, 0, 128};
        ntab[4]  = '{0, 1, 10, 128};
        ntab[5]  = '{1, 0, 40, 128};
        ntab[6]  = '{1, 1, -60, 128};
        ntab[7]  = '{0, 0, 1000, 128};
        ntab[8]  = '{0, 0, 1000, 128};
        ntab[9]  = '{0, 0, -1000, 128};
        ntab[10] = '{0, 0, -1000, 128};
        ntab[11] = '{0, 2, 64, 128};
        ntab[12] = '{0, 5, 64, 128};
        ntab[13] = '{0, 7, 64, 128};
        ntab[14] = '{0, 0, -3, 64};
        ntab[15] = '{0, 4, 1000, 255};

        vtab[0] = '{0, 3, 4, 1'b0, 125, 1, 6};
        vtab[1] = '{0, 3, 4, 1'b1, 100, 0, 6};
        vtab[2] = '{3, 4, 5, 1'b0, 40, 0, 9};
        vtab[3] = '{3, 4, 5, 1'b1, -60, 0, 9};
        vtab[4] = '{7, 2, 3, 1'b0, 1023, 0, 5};
        vtab[5] = '{9, 2, 3, 1'b0, -1024, 0, 5};
        vtab[6] = '{11, 3, 4, 1'b0, 64, 2, 6};
        vtab[7] = '{11, 3, 4, 1'b1, 64, 2, 6};
        vtab[8] = '{14, 1, 2, 1'b0, -2, 0, 4};
        vtab[9] = '{15, 1, 2, 1'b0, 1023, 4, 4};

        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_exp", int'(exp_w), 0);
        check("rst_act", int'(act_w), 0);
        check("rst_wr_ready", int'(wr_ready), 1);
        rst_n = 1'b1;

        for (int i = 0; i < 10; i++) begin
            load_vec(vtab[i]);
            start_wait(vtab[i].mn, lat);
            check($sformatf("v%0d_latency", i), lat, vtab[i].e_lat);
            check($sformatf("v%0d_exp", i), int'(exp_w), vtab[i].e_exp);
            check($sformatf("v%0d_act", i), int'(act_w), vtab[i].e_act);
            check($sformatf("v%0d_busy_in_done", i), int'(busy), 1);
            @(negedge clk);
            check($sformatf("v%0d_done_busy_after", i), int'({done, busy}), 0);
        end

        // Single-node tree via a zero count, which clamps up to one node.
        wr_node(0, 0, 0, 77, 128);
        set_nodes(0);
        start_wait(1'b0, lat);
        check("single_latency", lat, 1);
        check("single_exp", int'(exp_w), 77);

        // Loads, cfg and a second start during a sweep must all be dropped.
        load_vec(vtab[0]);
        @(negedge clk);
        start   = 1'b1;
        cfg_min = 1'b0;
        @(negedge clk);
        start = 1'b0;
        ndone = 0;
        rdy   = 0;
        nbusy = 0;
        e     = 0;
        a     = 0;
        for (int c = 1; c <= 12; c++) begin
            if (done) begin
                ndone++;
                e = int'(exp_w);
                a = int'(act_w);
            end
            if (c <= 6 && wr_ready) rdy++;
            if (c <= 6 && busy) nbusy++;
            if (c == 2) begin
                wr_en     = 1'b1;
                wr_addr   = W_ADDR'(3);
                wr_parent = '0;
                wr_action = W_ACT'(1);
                wr_reward = '0;
                wr_weight = W_WEIGHT'(64);
            end else if (c == 3) begin
                wr_en        = 1'b0;
                start        = 1'b1;
                cfg_nodes_en = 1'b1;
                cfg_nodes    = (W_ADDR+1)'(2);
            end else if (c == 4) begin
                start        = 1'b0;
                cfg_nodes_en = 1'b0;
            end
            @(negedge clk);
        end
        check("blk_done_count", ndone, 1);
        check("blk_wr_ready_high", rdy, 0);
        check("blk_busy_cycles", nbusy, 6);
        check("blk_exp", e, 125);
        check("blk_act", a, 1);
        start_wait(1'b0, lat);
        check("blk_rerun_latency", lat, 6);
        check("blk_rerun_exp", int'(exp_w), 125);
        check("blk_rerun_act", int'(act_w), 1);

        // Asynchronous reset between clock edges aborts a running sweep.
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        check("abort_busy_before", int'(busy), 1);
        #2 rst_n = 1'b0;
        #1;
        check("abort_busy", int'(busy), 0);
        check("abort_done", int'(done), 0);
        check("abort_exp", int'(exp_w), 0);
        check("abort_act", int'(act_w), 0);
        @(negedge clk);
        rst_n = 1'b1;
        ndone = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (done) ndone++;
        end
        check("abort_no_done", ndone, 0);
        set_nodes(4);
        start_wait(1'b0, lat);
        check("abort_rerun_latency", lat, 6);
        check("abort_rerun_exp", int'(exp_w), 125);
        check("abort_rerun_act", int'(act_w), 1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
